opb_regbank_ppc2simulink: RTL and testbench

OPB_REGBANK_PPC2SIMULINK -- requirements
Module: opb_regbank_ppc2simulink

---
 rtl/opb_regbank_ppc2simulink.sv | 213 +++++++++++++++++++++
 tb/tb_opb_regbank_ppc2simulink.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_regbank_ppc2simulink.sv
// opb_regbank_ppc2simulink
// OPB slave register bank that exposes C_NUM_REGS user registers to fabric
// logic. Every accepted transfer runs IDLE -> XFER -> RECOVER. The acknowledge
// and any read data appear only in the XFER cycle.
//
// Optional feature macro: OPB_REGBANK_SHADOW_COMMIT_EN
//   When defined, the registers are double-buffered. Writes land in shadow
//   registers and mark them dirty. A commit write to C_BASEADDR + 4*C_NUM_REGS
//   with DBus[31]=1 under BE[3] publishes all shadows at once.
//
// state   | meaning
// IDLE    | waiting for an address hit; the only state that accepts a transfer
// XFER    | acknowledge cycle; a write already took effect on the entering edge
// RECOVER | dead cycle so that a still-asserted select is not re-accepted
module opb_regbank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01188800,
    parameter logic [31:0] C_HIGHADDR    = 32'h011888FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter              C_FAMILY      = "virtex6",
    parameter int          C_NUM_REGS    = 4,
    parameter int          C_REG_WIDTH   = 32,
    parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]           OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]         OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]           OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]           Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]             user_wr_stb
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // The family only matters to the tool flow; it has no effect on the logic.
    localparam int          lp_unused_family_bits = $bits(C_FAMILY);
    localparam logic [31:0] LP_WMASK = 32'((64'd1 << C_REG_WIDTH) - 64'd1);
    localparam logic [C_REG_WIDTH-1:0] LP_RST = C_RESET_VALUE[C_REG_WIDTH-1:0];

    state_t r_state;
    state_t w_state_next;

    logic [31:0] w_addr;
    logic [31:0] w_offset;
    logic [29:0] w_idx;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_bmask;
    logic        w_hit;
    logic        w_accept;
    logic        w_wr_eff;
    logic [C_NUM_REGS-1:0] w_sel;
    logic [31:0] w_merge [C_NUM_REGS];
    logic [31:0] w_rdata;
    logic [31:0] w_dbus;
    logic        w_xfer_ack;
    logic        w_unused;

    logic                   r_rnw;
    logic [31:0]            r_rdata;
    logic [C_NUM_REGS-1:0]  r_wr_stb;
    logic [C_REG_WIDTH-1:0] r_reg [C_NUM_REGS];
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
    logic [C_REG_WIDTH-1:0] r_out [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]  r_dirty;
    logic                   w_commit_sel;
    logic                   w_commit;
`endif

    function automatic logic [31:0] f_ext(input logic [C_REG_WIDTH-1:0] v);
        f_ext = '0;
        f_ext[C_REG_WIDTH-1:0] = v;
    endfunction

    // OPB bit 0 is the MSB, so a plain cast puts DBus[31] at bit 0 here.
    assign w_addr   = 32'(OPB_ABus);
    assign w_wdata  = 32'(OPB_DBus);
    assign w_be     = 4'(OPB_BE);
    assign w_offset = w_addr - C_BASEADDR;
    assign w_idx    = w_offset[31:2];
    assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_accept = w_hit && (r_state == ST_IDLE);
    assign w_bmask  = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}} & LP_WMASK;
    // A write with no enabled byte inside the register width changes nothing.
    assign w_wr_eff = !OPB_RNW && (w_bmask != 32'h0);
    assign w_unused = ^{OPB_seqAddr, w_offset[1:0]};

    // Register decode, byte merge and read-data selection.
    always_comb begin
        w_sel   = '0;
        w_rdata = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            w_sel[i]   = (w_idx == 30'(i));
            w_merge[i] = (f_ext(r_reg[i]) & ~w_bmask) | (w_wdata & w_bmask);
            if (w_sel[i]) begin
                w_rdata = f_ext(r_reg[i]);
            end
        end
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
        w_commit_sel = (w_idx == 30'(C_NUM_REGS));
        w_commit     = !OPB_RNW && w_commit_sel && w_be[0] && w_wdata[0];
        if (w_commit_sel) begin
            w_rdata[C_NUM_REGS-1:0] = r_dirty;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_hit) w_state_next = ST_XFER;
            ST_XFER:    w_state_next = ST_RECOVER;
            ST_RECOVER: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: ack and read data only while in XFER, zero otherwise.
    always_comb begin
        w_xfer_ack = 1'b0;
        w_dbus     = '0;
        if (r_state == ST_XFER) begin
            w_xfer_ack = 1'b1;
            if (r_rnw) begin
                w_dbus = r_rdata;
            end
        end
    end

    // Register file update on the edge that enters XFER.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_rnw    <= 1'b0;
            r_rdata  <= '0;
            r_wr_stb <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_reg[i] <= LP_RST;
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
                r_out[i] <= LP_RST;
`endif
            end
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
            r_dirty <= '0;
`endif
        end else begin
            r_wr_stb <= '0;
            if (w_accept) begin
                r_rnw   <= OPB_RNW;
                r_rdata <= w_rdata;
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (w_wr_eff && w_sel[i]) begin
                        r_reg[i] <= w_merge[i][C_REG_WIDTH-1:0];
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
                        r_dirty[i] <= 1'b1;
`else
                        r_wr_stb[i] <= 1'b1;
`endif
                    end
                end
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
                // Commit decodes to its own address, so it never coincides
                // with a shadow write.
                if (w_commit) begin
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        r_out[i] <= r_reg[i];
                    end
                    r_wr_stb <= r_dirty;
                    r_dirty  <= '0;
                end
`endif
            end
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
        assign user_data_out[g*C_REG_WIDTH +: C_REG_WIDTH] = r_out[g];
`else
        assign user_data_out[g*C_REG_WIDTH +: C_REG_WIDTH] = r_reg[g];
`endif
    end

    assign user_wr_stb = r_wr_stb;
    assign Sl_DBus     = C_OPB_DWIDTH'(w_dbus);
    assign Sl_xferAck  = w_xfer_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_regbank_ppc2simulink.sv
// Bench for opb_regbank_ppc2simulink: one 32-bit-wide and one 12-bit-wide
// instance share the same OPB bus. A register-level model predicts every
// output on every cycle, and literal checks pin the model at key points.
module tb_opb_regbank_ppc2simulink;
    localparam logic [31:0] BASE = 32'h01188800;
    localparam logic [31:0] HIGH = 32'h011888FF;
    localparam logic [31:0] RSTV = 32'h0000005A;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [0:31] abus = '0;
    logic [0:3]  be   = '0;
    logic [0:31] dbus = '0;
    logic        rnw  = 1'b0;
    logic        sel  = 1'b0;
    logic        seqa = 1'b0;

    logic [0:31]  dbus_a, dbus_b;
    logic         ack_a, ack_b, err_a, err_b, rty_a, rty_b, tsup_a, tsup_b;
    logic [127:0] udo_a;
    logic [47:0]  udo_b;
    logic [3:0]   stb_a, stb_b;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    logic        exp_ack;
    logic [31:0] exp_dbus [2];
    logic [31:0] m_sh  [2][4];
    logic [31:0] m_out [2][4];
    logic [3:0]  m_dirty [2];
    logic [3:0]  m_stb   [2];

    logic        cap_ack;
    logic [31:0] cap_dbus [2];
    logic [3:0]  cap_stb  [2];

    opb_regbank_ppc2simulink #(.C_RESET_VALUE(32'h5A)) u_dut_a (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa),
        .Sl_DBus(dbus_a), .Sl_xferAck(ack_a), .Sl_errAck(err_a), .Sl_retry(rty_a),
        .Sl_toutSup(tsup_a), .user_data_out(udo_a), .user_wr_stb(stb_a)
    );

    opb_regbank_ppc2simulink #(.C_RESET_VALUE(32'h5A), .C_REG_WIDTH(12)) u_dut_b (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa),
        .Sl_DBus(dbus_b), .Sl_xferAck(ack_b), .Sl_errAck(err_b), .Sl_retry(rty_b),
        .Sl_toutSup(tsup_b), .user_data_out(udo_b), .user_wr_stb(stb_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] wmask(input int b);
        return (b == 0) ? 32'hFFFFFFFF : 32'h00000FFF;
    endfunction

    function automatic logic [31:0] udo_word(input int b, input int i);
        if (b == 0) return udo_a[i*32 +: 32];
        return {20'h0, udo_b[i*12 +: 12]};
    endfunction

    task automatic model_reset();
        exp_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            exp_dbus[b] = '0;
            m_dirty[b]  = '0;
            m_stb[b]    = '0;
            for (int i = 0; i < 4; i++) begin
                m_sh[b][i]  = RSTV & wmask(b);
                m_out[b][i] = RSTV & wmask(b);
            end
        end
    endtask

    // Effect of one accepted transfer as seen during its acknowledge cycle.
    task automatic model_xfer(input logic r, input logic [31:0] addr,
                              input logic [3:0] be_v, input logic [31:0] d);
        logic [31:0] bm;
        int idx;
        bm  = {{8{be_v[3]}}, {8{be_v[2]}}, {8{be_v[1]}}, {8{be_v[0]}}};
        idx = int'((addr - BASE) >> 2);
        exp_ack = 1'b1;
        for (int b = 0; b < 2; b++) begin
            m_stb[b]    = '0;
            exp_dbus[b] = '0;
            if (r) begin
                if (idx < 4) exp_dbus[b] = m_sh[b][idx];
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
                else if (idx == 4) exp_dbus[b] = {28'h0, m_dirty[b]};
`endif
            end else if (idx < 4 && (bm & wmask(b)) != 0) begin
                m_sh[b][idx] = ((m_sh[b][idx] & ~bm) | (d & bm)) & wmask(b);
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
                m_dirty[b][idx] = 1'b1;
`else
                m_out[b][idx] = m_sh[b][idx];
                m_stb[b][idx] = 1'b1;
`endif
            end
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
            else if (idx == 4 && be_v[0] && d[0]) begin
                for (int i = 0; i < 4; i++) m_out[b][i] = m_sh[b][i];
                m_stb[b]   = m_dirty[b];
                m_dirty[b] = '0;
            end
`endif
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ack_a", {31'h0, ack_a}, {31'h0, exp_ack});
            check("ack_b", {31'h0, ack_b}, {31'h0, exp_ack});
            check("dbus_a", dbus_a, exp_dbus[0]);
            check("dbus_b", dbus_b, exp_dbus[1]);
            check("stb_a", {28'h0, stb_a}, {28'h0, m_stb[0]});
            check("stb_b", {28'h0, stb_b}, {28'h0, m_stb[1]});
            check("tieoffs", {26'h0, err_a, rty_a, tsup_a, err_b, rty_b, tsup_b}, 32'h0);
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 4; i++)
                    check($sformatf("out%0d_%0d", b, i), udo_word(b, i), m_out[b][i]);
        end
    end

    // One bus transfer: request cycle, XFER, RECOVER; returns at IDLE.
    task automatic bus_xfer(input logic r, input logic [31:0] addr, input logic [3:0] be_v,
                            input logic [31:0] d, input logic s, input bit abort, input bit poke);
        logic hit;
        sel = s; rnw = r; abus = addr; be = be_v; dbus = d;
        hit = s && (addr >= BASE) && (addr <= HIGH);
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0;
        if (hit) model_xfer(r, addr, be_v, d);
        if (abort) rst = 1'b1;
        @(negedge clk);
        cap_ack     = ack_a;
        cap_dbus[0] = dbus_a;
        cap_dbus[1] = dbus_b;
        cap_stb[0]  = stb_a;
        cap_stb[1]  = stb_b;
        @(posedge clk); #1;
        exp_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            exp_dbus[b] = '0;
            m_stb[b]    = '0;
        end
        if (abort) begin
            rst = 1'b0;
            model_reset();
        end
        if (poke) begin
            sel = 1'b1; rnw = 1'b0; abus = BASE; be = 4'hF; dbus = 32'h0BADF00D;
        end
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be_v, input logic [31:0] d);
        bus_xfer(1'b0, addr, be_v, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] addr);
        bus_xfer(1'b1, addr, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_lit_a", udo_word(0, i), 32'h5A);
            check("rst_lit_b", udo_word(1, i), 32'h5A);
        end
        check("rst_lit_ack", {31'h0, ack_a}, 32'h0);
        check("rst_lit_dbus", dbus_a, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Shadow/commit sequence (immediate writes without the feature).
        wr(BASE + 32'h0, 4'hF, 32'h7);
        check("lit_ack_w7", {31'h0, cap_ack}, 32'h1);
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
        check("lit_stb_w7", {28'h0, cap_stb[0]}, 32'h0);
        check("lit_out0_w7", udo_word(0, 0), 32'h5A);
`else
        check("lit_stb_w7", {28'h0, cap_stb[0]}, 32'h1);
        check("lit_out0_w7", udo_word(0, 0), 32'h7);
`endif
        wr(BASE + 32'hC, 4'hF, 32'h9);
        rd(BASE + 32'h10);
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
        check("lit_dirty_rd", cap_dbus[0], 32'h9);
`else
        check("lit_commit_rd", cap_dbus[0], 32'h0);
`endif
        wr(BASE + 32'h10, 4'hF, 32'h1);
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
        check("lit_commit_stb", {28'h0, cap_stb[0]}, 32'h9);
`else
        check("lit_commit_stb", {28'h0, cap_stb[0]}, 32'h0);
`endif
        check("lit_out0_commit", udo_word(0, 0), 32'h7);
        check("lit_out3_commit", udo_word(0, 3), 32'h9);
        rd(BASE + 32'h10);
        check("lit_dirty_clr", cap_dbus[0], 32'h0);

        // Full and partial writes to register 2.
        wr(BASE + 32'h8, 4'hF, 32'hDEADBEEF);
        check("lit_ack_beef", {31'h0, cap_ack}, 32'h1);
`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
        check("lit_out2_beef", udo_word(0, 2), 32'h5A);
`else
        check("lit_stb_beef", {28'h0, cap_stb[0]}, 32'h4);
        check("lit_out2_beef", udo_word(0, 2), 32'hDEADBEEF);
        check("lit_out2_beef_b", udo_word(1, 2), 32'hEEF);
`endif
        wr(BASE + 32'h8, 4'b0011, 32'h11223344);
        rd(BASE + 32'h8);
        check("lit_rd2_a", cap_dbus[0], 32'hDEAD3344);
        check("lit_rd2_b", cap_dbus[1], 32'h344);

        // Width truncation and unmapped in-range address.
        wr(BASE + 32'h0, 4'hF, 32'hFFFFFFFF);
        rd(BASE + 32'h0);
        check("lit_rd0_a", cap_dbus[0], 32'hFFFFFFFF);
        check("lit_rd0_b", cap_dbus[1], 32'h00000FFF);
        rd(BASE + 32'h14);
        check("lit_nreg_ack", {31'h0, cap_ack}, 32'h1);
        check("lit_nreg_rd", cap_dbus[0], 32'h0);

        // Zero byte enables, misses and an idle bus.
        wr(BASE + 32'h4, 4'h0, 32'h12345678);
        check("lit_be0_ack", {31'h0, cap_ack}, 32'h1);
        check("lit_be0_stb", {28'h0, cap_stb[0]}, 32'h0);
        wr(BASE + 32'h100, 4'hF, 32'h1);
        check("lit_miss_hi", {31'h0, cap_ack}, 32'h0);
        wr(BASE - 32'h4, 4'hF, 32'h1);
        check("lit_miss_lo", {31'h0, cap_ack}, 32'h0);
        bus_xfer(1'b0, BASE + 32'h8, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
        check("lit_nosel", {31'h0, cap_ack}, 32'h0);

        // Byte-lane patterns on register 1.
        wr(BASE + 32'h4, 4'b0100, 32'hA1B2C3D4);
        wr(BASE + 32'h4, 4'b1000, 32'h11223344);
        wr(BASE + 32'h4, 4'b0110, 32'h55667788);
        wr(BASE + 32'h4, 4'b0001, 32'h000000FF);
        rd(BASE + 32'h4);
        check("lit_rd1_a", cap_dbus[0], 32'h116677FF);
        check("lit_rd1_b", cap_dbus[1], 32'h7FF);

        // A request during RECOVER must be ignored.
        bus_xfer(1'b1, BASE + 32'hC, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rd(BASE + 32'h0);
        check("lit_recover_ign", cap_dbus[0], 32'hFFFFFFFF);

        // Reset during XFER aborts the transfer.
        bus_xfer(1'b0, BASE + 32'h4, 4'hF, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
        check("lit_abort_ack", {31'h0, cap_ack}, 32'h1);
        check("lit_abort_out1", udo_word(0, 1), 32'h5A);
        check("lit_abort_out2", udo_word(0, 2), 32'h5A);
        rd(BASE + 32'h4);
        check("lit_abort_rd", cap_dbus[0], 32'h5A);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
